// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants, state encoding and index-width helper for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_core.sv
// Purely combinational 4-bit adder slice, time-shared by the sequencer.
module adder4_core (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built from one shared 4-bit adder, least-significant nibble first.
// Optional SUB_MODE_EN adds a 'sub' input that turns the operation into a - b.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    input  logic                    cin,
`ifdef SUB_MODE_EN
    input  logic                    sub,
`endif
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [4*NIBBLES-1:0]    sum,
    output logic                    cout,
    output logic                    busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     operandA_q, operandA_d;
    logic [W-1:0]     operandB_q, operandB_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [IDX_W+1:0] bitBase;
    logic [3:0]       coreA, coreB, coreS;
    logic             coreCout;
    logic [W-1:0]     bLatch;
    logic             carryLatch;

    assign bitBase = {idx_q, 2'b00};
    assign coreA   = operandA_q[bitBase +: NIBBLE_W];
    assign coreB   = operandB_q[bitBase +: NIBBLE_W];

    adder4_core u_core (
        .A    (coreA),
        .B    (coreB),
        .Cin  (carry_q),
        .S    (coreS),
        .Cout (coreCout)
    );

    // Subtraction is a + ~b + 1, so the only difference is what gets latched.
`ifdef SUB_MODE_EN
    assign bLatch     = sub ? ~b : b;
    assign carryLatch = sub ? 1'b1 : cin;
`else
    assign bLatch     = b;
    assign carryLatch = cin;
`endif

    always_comb begin
        state_d    = state_q;
        operandA_d = operandA_q;
        operandB_d = operandB_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    operandA_d = a;
                    operandB_d = bLatch;
                    carry_d    = carryLatch;
                    idx_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                sum_d[bitBase +: NIBBLE_W] = coreS;
                carry_d = coreCout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = coreCout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            operandA_q <= '0;
            operandB_q <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            operandA_q <= operandA_d;
            operandB_q <= operandB_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs a wide (4*NIBBLES-bit) addition by time-sharing one 4-bit adder core, least-significant nibble first. The carry from each nibble's Cout is registered and fed to the next nibble's Cin. Operands are latched on a valid/ready start handshake. The result is returned on a valid/ready result handshake. It sits between a requesting datapath and the shared 4-bit adder, trading area for latency.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES); legal range 2..16.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
start_valid  in  1  requester presents an operation.
start_ready  out  1  block can accept an operation (high only in IDLE).
a  in  W  operand A; sampled on start handshake.
b  in  W  operand B; sampled on start handshake.
cin  in  1  initial carry-in; sampled on start handshake.
res_valid  out  1  sum/cout valid.
res_ready  in  1  consumer accepts result.
sum  out  W  result.
cout  out  1  carry out of the most-significant nibble.
busy  out  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, start_ready=1, res_valid=0, busy=0, sum=0, cout=0, nibble index=0, carry register=0.
- FSM states:
  - IDLE: start_ready=1. On start_valid&&start_ready, latch a, b, cin into operand/carry registers, clear the index, and go to RUN.
  - RUN: each cycle, feed nibble[idx] of A and B plus the carry register to the adder core. Write S into sum[4*idx+3:4*idx] and Cout into the carry register, then increment idx. At idx==NIBBLES-1, also load cout from the core's Cout and go to DONE.
  - DONE: res_valid=1. sum and cout are held stable while res_ready=0. On res_ready, go to IDLE; res_valid drops the next cycle.
- Latency: res_valid rises exactly NIBBLES+1 cycles after the start handshake cycle. Minimum period between accepted operations is NIBBLES+2 cycles.
- start_valid in RUN or DONE is ignored; no operand change is observed. The requester holds a/b/cin until start_ready.
- Arithmetic: sum = (a + b + cin) mod 2^W; cout = bit W of the full sum. The carry chain wraps only at the top nibble, never between operations.
- Upper nibbles of sum not yet written in RUN hold their prior-operation values. Consumers use sum only when res_valid=1.
- rst asserted in any state, including mid-RUN: the next cycle is IDLE with all reset values. The partial result is discarded and no res_valid is produced.
- The adder core is purely combinational; all registers live in this block.

Optional Feature:
SUB_MODE_EN.
- Defined: adds input port sub (1 bit), sampled on the start handshake. When sub=1, B is stored inverted and the initial carry is forced to 1, ignoring cin. The result is sum=(a-b) mod 2^W, and cout=1 means no borrow.
- Undefined: the port is absent and the block is addition only; behaviour is otherwise identical.

Decomposition:
- Shared package: NIBBLE_W=4 constant; state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2; index width function clog2(NIBBLES).
- One sub-module: adder4_core, a 4-bit combinational adder with ports A[3:0], B[3:0], Cin, S[3:0], Cout, instantiated once.

Test Plan:
1. NIBBLES=4, a=16'h00FF, b=16'h0001, cin=0 -> sum=16'h0100, cout=0, res_valid exactly 5 cycles after the handshake.
2. a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Then a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
3. Backpressure: res_ready=0 for 3 cycles in DONE -> sum/cout/res_valid held stable. start_valid=1 throughout -> start_ready=0 and no new operation accepted until one cycle after res_ready.
4. Reset mid-RUN: start a=16'h1234, b=16'h1111, assert rst at RUN idx=2 -> next cycle IDLE, start_ready=1, res_valid=0, sum=0. A subsequent operation of 16'h0003+16'h0004 yields 16'h0007.
5. Back-to-back: 20 random operand pairs with random cin and random res_ready stalls -> every result matches (a+b+cin) mod 2^16 and carry; no result dropped or duplicated.
6. SUB_MODE_EN defined: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0. With a=16'h0007, b=16'h0005, sub=1 -> sum=16'h0002, cout=1.
